// File: rtl/sample_stream_buffer_pkg.sv
// Shared types and default constants for the sample stream buffer.
// The buffer FSM encoding lives here so that the RTL and the bench agree on it.
package sample_buf_pkg;

  localparam int unsigned INP_BW_DEF     = 32'd8;
  localparam int unsigned DEPTH_LOG2_DEF = 32'd9;
  localparam int unsigned FRAME_LEN_DEF  = 32'd256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_STREAM = 2'd2
  } buf_state_e;

  // Saturating increment used by the dropped-write counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/sample_stream_buffer_if.sv
// Producer/consumer handshake bundle of the sample stream buffer.
// The master modport is the environment side, the slave modport is the buffer.
interface sample_stream_buffer_if
  import sample_buf_pkg::*;
#(
  parameter int unsigned INP_BW = INP_BW_DEF
);

  logic              i_wr;
  logic [INP_BW-1:0] i_wdata;
  logic              o_full;
  logic              o_empty;
  logic              o_start_p;
  logic              i_rd;
  logic              o_rdy;
  logic [INP_BW-1:0] o_rdata;
  logic              o_ovf;

  modport master (
    output i_wr, i_wdata, i_rd,
    input  o_full, o_empty, o_start_p, o_rdy, o_rdata, o_ovf
  );

  modport slave (
    input  i_wr, i_wdata, i_rd,
    output o_full, o_empty, o_start_p, o_rdy, o_rdata, o_ovf
  );

endinterface

// File: rtl/sample_stream_buffer_ram.sv
// Simple dual-port sample storage: synchronous write, registered read (1-cycle latency).
// The read register holds its value between reads and resets to zero.
module sample_buf_ram
  import sample_buf_pkg::*;
#(
  parameter int unsigned INP_BW     = INP_BW_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  i_clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [INP_BW-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [INP_BW-1:0]     rd_data
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

  logic [INP_BW-1:0] mem_q [DEPTH];
  logic [INP_BW-1:0] rd_data_q;
  logic [INP_BW-1:0] rd_data_d;

  // Storage array write port.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read data capture; hold the last sample when not reading.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read data register.
  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      rd_data_q <= {INP_BW{1'b0}};
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sample_stream_buffer.sv
// Circular sample FIFO feeding the max stage: buffers a frame, pulses start, serves reads.
// Optional SAMPLE_BUF_DROP_CNT_EN adds a saturating 16-bit dropped-write counter port.
module sample_stream_buffer
  import sample_buf_pkg::*;
#(
  parameter int unsigned INP_BW     = INP_BW_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned FRAME_LEN  = FRAME_LEN_DEF
) (
  input  logic                  i_clk,
  input  logic                  reset_n,
  sample_stream_buffer_if.slave bus
`ifdef SAMPLE_BUF_DROP_CNT_EN
  ,
  output logic [15:0]           o_drop_cnt
`endif
);

  localparam int unsigned PW = DEPTH_LOG2 + 32'd1;
  localparam int unsigned FRAME_LEN_I = FRAME_LEN;
  localparam logic [PW-1:0] FRAME_LEN_W = FRAME_LEN_I[PW-1:0];
  localparam logic [PW-1:0] DEPTH_W     = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PW-1:0] PTR_LAST    = {1'b0, {DEPTH_LOG2{1'b1}}};
  localparam logic [PW-1:0] ONE_W       = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [PW-1:0] ZERO_W      = {PW{1'b0}};

  buf_state_e    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] frame_cnt_q, frame_cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          rdy_q, rdy_d;
  logic          start_q, start_d;
  logic          wr_accept;
  logic          wr_drop;
  logic          pop;

  // Datapath next-state: pointers, occupancy and flags.
  always_comb begin
    wr_accept = bus.i_wr & ~full_q;
    wr_drop   = bus.i_wr & full_q;
    pop       = bus.i_rd & ~empty_q & (state_q == ST_STREAM);

    wr_ptr_d = wr_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? ZERO_W : (wr_ptr_q + ONE_W);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? ZERO_W : (rd_ptr_q + ONE_W);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_accept, pop})
      2'b10:   count_d = count_q + ONE_W;
      2'b01:   count_d = count_q - ONE_W;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == DEPTH_W);
    empty_d = (count_d == ZERO_W);
    ovf_d   = ovf_q | wr_drop;
    rdy_d   = pop;
  end

  // Frame FSM: wait for a full frame, pulse start, then count pops until the frame is delivered.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    start_d     = (state_q == ST_ARM);
    case (state_q)
      ST_IDLE: begin
        if (count_q >= FRAME_LEN_W) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        frame_cnt_d = ZERO_W;
        state_d     = ST_STREAM;
      end
      ST_STREAM: begin
        if (pop) begin
          frame_cnt_d = frame_cnt_q + ONE_W;
          if (frame_cnt_d == FRAME_LEN_W) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        frame_cnt_d = ZERO_W;
      end
    endcase
  end

  // State and flag registers.
  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= ZERO_W;
      rd_ptr_q    <= ZERO_W;
      count_q     <= ZERO_W;
      frame_cnt_q <= ZERO_W;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      ovf_q       <= 1'b0;
      rdy_q       <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_cnt_q <= frame_cnt_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      ovf_q       <= ovf_d;
      rdy_q       <= rdy_d;
      start_q     <= start_d;
    end
  end

`ifdef SAMPLE_BUF_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Dropped-write counter, saturating.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (wr_drop) begin
      drop_cnt_d = sat_inc16(drop_cnt_q);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Dropped-write counter register.
  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

  sample_buf_ram #(
    .INP_BW     (INP_BW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .i_clk   (i_clk),
    .reset_n (reset_n),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wr_data (bus.i_wdata),
    .rd_en   (pop),
    .rd_addr (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rd_data (bus.o_rdata)
  );

  assign bus.o_full    = full_q;
  assign bus.o_empty   = empty_q;
  assign bus.o_start_p = start_q;
  assign bus.o_rdy     = rdy_q;
  assign bus.o_ovf     = ovf_q;

endmodule

// File: tb/tb_sample_stream_buffer.sv
// Scoreboard bench for sample_stream_buffer: stimulus pushes expected samples,
// a monitor pops and compares on every o_rdy and tracks frame boundaries.
module tb_sample_stream_buffer;
  import sample_buf_pkg::*;

  localparam int FL = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sample_stream_buffer_if #(.INP_BW(8)) bus();
`ifdef SAMPLE_BUF_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  sample_stream_buffer #(
    .INP_BW     (8),
    .DEPTH_LOG2 (9),
    .FRAME_LEN  (FL)
  ) dut (
    .i_clk   (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef SAMPLE_BUF_DROP_CNT_EN
    ,
    .o_drop_cnt (drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int rdy_total = 0;
  int start_total = 0;
  int frame_left = 0;
  int rdy_base = 0;
  logic mon_rd;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: start pulses open a frame, every o_rdy is compared against the scoreboard.
  always @(posedge clk) begin
    mon_rd = bus.i_rd;
    #1;
    if (bus.o_start_p === 1'b1) begin
      start_total++;
      check("frame_overlap", frame_left, 0);
      frame_left = FL;
    end
    if (bus.o_rdy === 1'b1) begin
      rdy_total++;
      check("rdy_needs_rd", mon_rd, 1);
      check("rdy_in_frame", (frame_left > 0) ? 1 : 0, 1);
      if (frame_left > 0) frame_left--;
      if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
      else check("rdata", bus.o_rdata, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_burst(input int n, input int base, input int accept_n, input bit toggle_rd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_wr = 1'b1;
      bus.i_wdata = 8'(base + i);
      if (toggle_rd) bus.i_rd = i[0];
      if (i < accept_n) exp_q.push_back(8'(base + i));
    end
    @(negedge clk);
    bus.i_wr = 1'b0;
  endtask

  task automatic wait_rdy(input int target, input int budget, input string name);
    int n = 0;
    while (rdy_total < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, rdy_total, target);
  endtask

  task automatic wait_start(input int target, input int budget, input string name);
    int n = 0;
    while (start_total < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, start_total, target);
  endtask

  initial begin
    bus.i_wr = 1'b0;
    bus.i_wdata = 8'd0;
    bus.i_rd = 1'b0;
    reset_n = 1'b0;
    tick(3);
    check("rst_empty", bus.o_empty, 1);
    check("rst_full", bus.o_full, 0);
    check("rst_start", bus.o_start_p, 0);
    check("rst_rdy", bus.o_rdy, 0);
    check("rst_rdata", bus.o_rdata, 0);
    check("rst_ovf", bus.o_ovf, 0);
    check("rst_state", dut.state_q, ST_IDLE);
    reset_n = 1'b1;

    // Reads against an empty buffer
    bus.i_rd = 1'b1;
    tick(50);
    check("t1_no_rdy", rdy_total, 0);
    check("t1_no_start", start_total, 0);
    check("t1_empty", bus.o_empty, 1);

    // One frame 0..255 with reads held high; start two edges after the last write
    write_burst(256, 0, 256, 1'b0);
    @(posedge clk); #1;
    check("t2_start_early", bus.o_start_p, 0);
    @(posedge clk); #1;
    check("t2_start_edge", bus.o_start_p, 1);
    wait_rdy(256, 400, "t2_drain");
    tick(3);
    check("t2_idle", dut.state_q, ST_IDLE);
    check("t2_empty", bus.o_empty, 1);
    check("t2_starts", start_total, 1);

    // Pointer wrap 511->0 with toggled reads and concurrent writes
    bus.i_rd = 1'b0;
    write_burst(256, 100, 256, 1'b0);
    wait_start(2, 20, "t5_start");
    write_burst(256, 356, 256, 1'b1);
    bus.i_rd = 1'b1;
    wait_rdy(768, 1500, "t5_drain");
    tick(3);
    check("t5_starts", start_total, 3);
    check("t5_empty", bus.o_empty, 1);
    check("t5_wr_ptr", dut.wr_ptr_q, 256);
    check("t5_ovf", bus.o_ovf, 0);

    // 255 samples are not a frame; the 256th is
    write_burst(255, 20, 255, 1'b0);
    tick(10);
    check("t3_no_start", start_total, 3);
    check("t3_no_rdy", rdy_total, 768);
    write_burst(1, 275, 1, 1'b0);
    wait_start(4, 10, "t3_start");
    wait_rdy(1024, 400, "t3_drain");
    tick(3);

    // Fill to full, overflow by 8, then deliver two frames
    bus.i_rd = 1'b0;
    write_burst(512, 0, 512, 1'b0);
    check("t4_full", bus.o_full, 1);
    check("t4_ovf_pre", bus.o_ovf, 0);
    write_burst(8, 512, 0, 1'b0);
    check("t4_ovf", bus.o_ovf, 1);
    check("t4_full_hold", bus.o_full, 1);
`ifdef SAMPLE_BUF_DROP_CNT_EN
    check("t4_drop_cnt", drop_cnt, 8);
`endif
    bus.i_rd = 1'b1;
    wait_rdy(1536, 1500, "t4_drain");
    tick(3);
    check("t4_starts", start_total, 6);
    check("t4_empty", bus.o_empty, 1);
    check("t4_ovf_sticky", bus.o_ovf, 1);

    // Reset in the middle of a streamed frame
    bus.i_rd = 1'b0;
    write_burst(256, 50, 256, 1'b0);
    wait_start(7, 20, "t6_start");
    bus.i_rd = 1'b1;
    tick(10);
    reset_n = 1'b0;
    bus.i_rd = 1'b0;
    @(posedge clk); #1;
    check("t6_rdy", bus.o_rdy, 0);
    check("t6_empty", bus.o_empty, 1);
    check("t6_ovf", bus.o_ovf, 0);
    check("t6_full", bus.o_full, 0);
    check("t6_rdata", bus.o_rdata, 0);
    check("t6_state", dut.state_q, ST_IDLE);
`ifdef SAMPLE_BUF_DROP_CNT_EN
    check("t6_drop_cnt", drop_cnt, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    frame_left = 0;
    rdy_base = rdy_total;
    bus.i_rd = 1'b1;
    write_burst(256, 7, 256, 1'b0);
    wait_start(8, 20, "t6_restart");
    wait_rdy(rdy_base + 256, 400, "t6_drain");
    tick(3);
    check("t6_empty_end", bus.o_empty, 1);
    check("sb_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_stream_buffer.md
Name: sample_stream_buffer

Overview:
- Circular sample FIFO that sits directly upstream of the max computation stage.
- Captures producer samples, then issues a one-cycle start pulse once a full frame of FRAME_LEN samples is buffered.
- Serves the downstream read-request/ready handshake: a level read request is answered by a one-cycle ready pulse with the data.
- Tracks frame progress so a new start is issued only after the previous frame has been fully delivered.

Parameters:
- INP_BW, 8, sample width in bits.
- DEPTH_LOG2, 9, log2 of FIFO depth; depth = 512 entries.
- FRAME_LEN, 256, samples per frame; must satisfy 1 <= FRAME_LEN <= 2^DEPTH_LOG2.

Ports:
- i_clk, in, 1, clock; all logic on the rising edge.
- reset_n, in, 1, synchronous active-low reset.
- i_wr, in, 1, producer write strobe.
- i_wdata, in, INP_BW, producer sample.
- o_full, out, 1, FIFO holds 2^DEPTH_LOG2 entries.
- o_empty, out, 1, FIFO holds 0 entries.
- o_start_p, out, 1, one-cycle frame start pulse to the downstream stage.
- i_rd, in, 1, downstream read request (level).
- o_rdy, out, 1, read data valid pulse.
- o_rdata, out, INP_BW, read sample; held between pulses.
- o_ovf, out, 1, sticky flag: a write was dropped.

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock, i_clk; reset_n is synchronous, active-low.
  - While reset_n=0 at a clock edge: pointers=0, count=0, o_empty=1, o_full=0, o_start_p=0, o_rdy=0, o_rdata=0, o_ovf=0, FSM=IDLE, frame counter=0.
  - Reset mid-frame discards all buffered data; there is no partial-frame recovery.
- Storage:
  - Write pointer, read pointer and count are each DEPTH_LOG2+1 bits (count reaches 2^DEPTH_LOG2).
  - Pointers wrap modulo 2^DEPTH_LOG2.
  - o_full and o_empty are registered and derived from count.
- Write:
  - Accepted when i_wr=1 and o_full=0; the write pointer increments.
  - When i_wr=1 and o_full=1, the sample is dropped and o_ovf is set; o_ovf clears only on reset.
  - A read in the same cycle does not unblock a write while full.
- Read:
  - A pop occurs when i_rd=1, o_empty=0 and FSM=STREAM.
  - The cycle after a pop: o_rdy=1 and o_rdata=the popped sample (1-cycle latency). At most one pop per cycle.
  - i_rd while empty or while not in STREAM yields no pop and no o_rdy.
  - No bypass: a sample written in cycle N is poppable no earlier than cycle N+1.
  - A simultaneous accepted write and pop leave count unchanged.
- FSM:
  - IDLE -> ARM when count >= FRAME_LEN.
  - ARM: o_start_p=1 for exactly one cycle; the frame counter clears; next state is STREAM.
  - STREAM: the frame counter increments on each pop. On the pop that makes it FRAME_LEN, go to IDLE in the next cycle.
  - The next frame can therefore start no sooner than 2 cycles after the last pop of the previous frame.
  - Downstream i_rd deasserting mid-frame stalls delivery; the FSM stays in STREAM.
- Width rules: count comparisons are unsigned; FRAME_LEN is compared after zero-extension to DEPTH_LOG2+1 bits.

Optional Feature:
- Macro: SAMPLE_BUF_DROP_CNT_EN.
- When defined:
  - Adds output port o_drop_cnt, 16 bits.
  - o_drop_cnt increments on each dropped write and saturates at 0xFFFF.
  - Reset value is 0.
- When undefined: the port and counter are absent; o_ovf behaviour is unchanged.

Decomposition:
- Shared package sample_buf_pkg holds:
  - FSM state encoding: IDLE=2'd0, ARM=2'd1, STREAM=2'd2.
  - Default constants for INP_BW, DEPTH_LOG2 and FRAME_LEN.
- One natural sub-module: sample_buf_ram, a simple dual-port register array (synchronous write, synchronous read, 1-cycle latency) of 2^DEPTH_LOG2 x INP_BW.
- The top level owns pointers, count, FSM and flags.

Test Plan:
- Reset then no writes; i_rd=1 for 50 cycles -> o_rdy never asserts, o_start_p=0, o_empty=1.
- Write 256 samples 0..255 back-to-back -> o_start_p pulses once, 2 cycles after the 256th write edge. With i_rd held at 1, exactly 256 o_rdy pulses follow, o_rdata=0..255 in order, then FSM=IDLE and o_empty=1.
- Write 255 samples -> no o_start_p. Write a 256th -> o_start_p fires.
- Write 520 samples with no reads -> o_full=1 after 512 accepted writes and o_ovf=1. With SAMPLE_BUF_DROP_CNT_EN, o_drop_cnt=8. Two frames are then delivered as 0..255 and 256..511 (values taken mod 256 at INP_BW=8).
- Mid-frame, toggle i_rd 1/0 every cycle while writing concurrently at the wrap point (pointer 511->0) -> o_rdata order is preserved, exactly FRAME_LEN o_rdy pulses are delivered per start, and no o_rdy occurs while i_rd is low.
- Assert reset_n=0 for one cycle in the middle of STREAM -> the next cycle shows o_rdy=0, o_empty=1, o_ovf=0, FSM=IDLE; subsequent writes of 256 samples produce a fresh o_start_p.
